// File: rtl/sram_ctrl_if.sv
// Host-side request/response bundle for sram_ctrl.
// The master drives requests and the slave (controller) returns completions.
interface sram_ctrl_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
);
  localparam int unsigned AW = $clog2(ROWS);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_err;
  logic [COLS-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// SRAM array sequencer: precharge -> wordline access -> sense (reads only) -> response.
// Every output comes straight from a flop so the analog controls never see decode glitches.
module sram_ctrl #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned PRE_CYCLES   = 2,
  parameter int unsigned WL_CYCLES    = 2,
  parameter int unsigned SENSE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  sram_ctrl_if.slave      bus,
  output logic            precharge_en,
  output logic [ROWS-1:0] wl_sel,
  output logic            wr_en,
  output logic [COLS-1:0] wr_data,
  output logic            sae,
  input  logic [COLS-1:0] sa_out
);

  localparam int unsigned AW      = $clog2(ROWS);
  localparam int unsigned MAX_PW  = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_PW > SENSE_CYCLES) ? MAX_PW : SENSE_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  localparam logic [AW:0]   ROWS_LIM   = (AW+1)'(ROWS);
  localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] WL_LAST    = CW'(WL_CYCLES - 1);
  localparam logic [CW-1:0] SENSE_LAST = CW'(SENSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACCESS,
    S_SENSE,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;

  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [COLS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            precharge_en_q, precharge_en_d;
  logic [ROWS-1:0] wl_sel_q, wl_sel_d;
  logic            wr_en_q, wr_en_d;
  logic [COLS-1:0] wr_data_q, wr_data_d;
  logic            sae_q, sae_d;

  logic            accept_c;
  logic            addr_oor_c;

  // Next state, then all outputs decoded from the next state so they register in step with it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    we_d        = we_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    accept_c   = bus.req_valid && req_ready_q;
    addr_oor_c = {1'b0, bus.req_addr} >= ROWS_LIM;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept_c) begin
          we_d   = bus.req_we;
          addr_d = bus.req_addr;
          if (bus.req_we) begin
            wr_data_d = bus.req_wdata;
          end
          if (addr_oor_c) begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = S_PRE;
          end
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        if (cnt_q == WL_LAST) begin
          state_d = we_q ? S_RESP : S_SENSE;
          cnt_d   = '0;
        end
      end
      S_SENSE: begin
        if (cnt_q == SENSE_LAST) begin
          state_d     = S_RESP;
          cnt_d       = '0;
          rsp_rdata_d = sa_out;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    req_ready_d    = (state_d == S_IDLE);
    rsp_valid_d    = (state_d == S_RESP);
    precharge_en_d = (state_d == S_PRE);
    wr_en_d        = (state_d == S_ACCESS) && we_d;
    sae_d          = (state_d == S_SENSE);
    wl_sel_d       = ((state_d == S_ACCESS) || (state_d == S_SENSE)) ? (ROWS'(1) << addr_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      precharge_en_q <= 1'b0;
      wl_sel_q       <= '0;
      wr_en_q        <= 1'b0;
      wr_data_q      <= '0;
      sae_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
      precharge_en_q <= precharge_en_d;
      wl_sel_q       <= wl_sel_d;
      wr_en_q        <= wr_en_d;
      wr_data_q      <= wr_data_d;
      sae_q          <= sae_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign precharge_en  = precharge_en_q;
  assign wl_sel        = wl_sel_q;
  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign sae           = sae_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: dut0 uses default timing with 8 rows, dut1 uses 6 rows with 1/3/2 phase lengths.
// A timeline model predicts every output each cycle; directed tests pin latencies and values.
module tb_sram_ctrl;

  logic clk;
  logic rst;

  logic       req_valid [2];
  logic       req_we    [2];
  logic [2:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic [7:0] sa_val    [2];

  logic       rdy_o   [2];
  logic       rv_o    [2];
  logic       err_o   [2];
  logic [7:0] rdata_o [2];
  logic       pre_o   [2];
  logic [7:0] wl_o    [2];
  logic       wren_o  [2];
  logic [7:0] wdata_o [2];
  logic       sae_o   [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int age    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned G_ROWS  = (g == 0) ? 8 : 6;
    localparam int unsigned G_PRE   = (g == 0) ? 2 : 1;
    localparam int unsigned G_WL    = (g == 0) ? 2 : 3;
    localparam int unsigned G_SENSE = (g == 0) ? 1 : 2;

    logic              pre_w;
    logic [G_ROWS-1:0] wl_w;
    logic              wr_en_w;
    logic [7:0]        wd_w;
    logic              sae_w;
    logic [7:0]        sa_w;

    sram_ctrl_if #(.ROWS(G_ROWS), .COLS(8)) bus ();

    assign bus.req_valid = req_valid[g];
    assign bus.req_we    = req_we[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];

    // Sense amps show the stored word only while enabled, garbage otherwise.
    assign sa_w = sae_w ? sa_val[g] : ~sa_val[g];

    sram_ctrl #(
      .ROWS(G_ROWS), .COLS(8),
      .PRE_CYCLES(G_PRE), .WL_CYCLES(G_WL), .SENSE_CYCLES(G_SENSE)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .precharge_en (pre_w),
      .wl_sel       (wl_w),
      .wr_en        (wr_en_w),
      .wr_data      (wd_w),
      .sae          (sae_w),
      .sa_out       (sa_w)
    );

    assign rdy_o[g]   = bus.req_ready;
    assign rv_o[g]    = bus.rsp_valid;
    assign err_o[g]   = bus.rsp_err;
    assign rdata_o[g] = bus.rsp_rdata;
    assign pre_o[g]   = pre_w;
    assign wl_o[g]    = 8'(wl_w);
    assign wren_o[g]  = wr_en_w;
    assign wdata_o[g] = wd_w;
    assign sae_o[g]   = sae_w;
  end

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, id, cyc, act, exp);
    end
  endtask

  // Model state: one outstanding request per DUT, described by its accept cycle.
  bit         busy   [2];
  int         t0     [2];
  bit         m_we   [2];
  int         m_addr [2];
  bit         m_err  [2];
  logic [7:0] m_wdata[2];
  logic [7:0] m_rdata[2];

  int         mp, mw, ms, md, mend, mrows;
  bit         e_pre, e_acc, e_sen, e_rv, e_ready, ovl;
  logic [7:0] e_wl;

  always @(negedge clk) begin
    cyc++;
    if (rst) age = 0;
    else if (age < 3) age++;
    for (int id = 0; id < 2; id++) begin
      mp    = (id == 0) ? 2 : 1;
      mw    = (id == 0) ? 2 : 3;
      ms    = (id == 0) ? 1 : 2;
      mrows = (id == 0) ? 8 : 6;
      e_pre = 1'b0; e_acc = 1'b0; e_sen = 1'b0; e_rv = 1'b0; md = 0;
      if (rst) begin
        busy[id]    = 1'b0;
        m_wdata[id] = 8'h00;
        m_rdata[id] = 8'h00;
      end else if (busy[id]) begin
        md    = cyc - t0[id];
        mend  = m_err[id] ? 0 : (mp + mw + (m_we[id] ? 0 : ms));
        e_pre = !m_err[id] && md >= 1 && md <= mp;
        e_acc = !m_err[id] && md > mp && md <= mp + mw;
        e_sen = !m_err[id] && !m_we[id] && md > mp + mw && md <= mp + mw + ms;
        e_rv  = (md == mend + 1);
      end
      e_wl    = (e_acc || e_sen) ? 8'(1 << m_addr[id]) : 8'h00;
      e_ready = !rst && age >= 2 && !busy[id];

      chk("req_ready", id, 32'(rdy_o[id]), 32'(e_ready));
      chk("rsp_valid", id, 32'(rv_o[id]), 32'(e_rv));
      chk("rsp_err", id, 32'(err_o[id]), 32'(e_rv && m_err[id]));
      chk("rsp_rdata", id, 32'(rdata_o[id]), 32'(m_rdata[id]));
      chk("precharge_en", id, 32'(pre_o[id]), 32'(e_pre));
      chk("wl_sel", id, 32'(wl_o[id]), 32'(e_wl));
      chk("wr_en", id, 32'(wren_o[id]), 32'(e_acc && m_we[id]));
      chk("wr_data", id, 32'(wdata_o[id]), 32'(m_wdata[id]));
      chk("sae", id, 32'(sae_o[id]), 32'(e_sen));
      ovl = (pre_o[id] && (wl_o[id] != 8'h00 || wren_o[id] || sae_o[id])) || (wren_o[id] && sae_o[id]);
      chk("phase_overlap", id, 32'(ovl), 32'(0));

      if (!rst) begin
        if (e_sen && md == mp + mw + ms) m_rdata[id] = sa_val[id];
        if (e_rv) busy[id] = 1'b0;
        if (e_ready && req_valid[id]) begin
          busy[id]   = 1'b1;
          t0[id]     = cyc;
          m_we[id]   = req_we[id];
          m_addr[id] = 32'(req_addr[id]);
          m_err[id]  = 32'(req_addr[id]) >= mrows;
          if (req_we[id]) m_wdata[id] = req_wdata[id];
        end
      end
    end
  end

  // Latency counts the cycle in which rsp_valid is visible, with the accept cycle as 0.
  task automatic run_req(input int id, input bit we, input logic [2:0] addr, input logic [7:0] wd,
                         output int lat, output logic err, output logic [7:0] rd,
                         output logic [7:0] wl_or, output int npre, output int nwl, output int nsae);
    bit got;
    got = 1'b0; lat = 0; err = 1'b0; rd = 8'h00; wl_or = 8'h00; npre = 0; nwl = 0; nsae = 0;
    @(posedge clk); #1;
    req_valid[id] = 1'b1; req_we[id] = we; req_addr[id] = addr; req_wdata[id] = wd;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = rdy_o[id];
    end
    chk("accept_wait", id, 32'(got), 32'(1));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      lat++;
      if (pre_o[id]) npre++;
      if (wl_o[id] != 8'h00) nwl++;
      if (sae_o[id]) nsae++;
      wl_or = wl_or | wl_o[id];
      if (rv_o[id]) begin
        got = 1'b1;
        err = err_o[id];
        rd  = rdata_o[id];
      end
    end
    chk("rsp_wait", id, 32'(got), 32'(1));
  endtask

  task automatic back_to_back(output int gap1, output int gap2);
    int t;
    int ta [3];
    bit got;
    t = 0;
    sa_val[0] = 8'h77;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 3'd1; req_wdata[0] = 8'h11;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      ta[k] = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        t++;
        if (rdy_o[0]) begin
          got   = 1'b1;
          ta[k] = t;
        end
      end
      chk("b2b_accept_wait", 0, 32'(got), 32'(1));
      @(posedge clk); #1;
      if (k == 0) begin
        req_we[0] = 1'b0; req_addr[0] = 3'd2; req_wdata[0] = 8'hEE;
      end else if (k == 1) begin
        req_we[0] = 1'b1; req_addr[0] = 3'd6; req_wdata[0] = 8'h99;
      end else begin
        req_valid[0] = 1'b0;
      end
    end
    gap1 = ta[1] - ta[0];
    gap2 = ta[2] - ta[1];
  endtask

  initial begin
    int         lat, npre, nwl, nsae, gap1, gap2;
    logic       err;
    logic [7:0] rd, wl_or;
    bit         got;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 3'd0; req_wdata[i] = 8'h00; sa_val[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_low", 0, 32'(rdy_o[0]), 32'(0));
    chk("reset_wl_sel", 0, 32'(wl_o[0]), 32'(0));
    chk("reset_rdata", 0, 32'(rdata_o[0]), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_first_clock", 0, 32'(rdy_o[0]), 32'(0));
    @(negedge clk);
    chk("ready_after_first_clock", 0, 32'(rdy_o[0]), 32'(1));

    // Default timing: write row 3, read it back, then a write that must not disturb rdata.
    run_req(0, 1'b1, 3'd3, 8'hA5, lat, err, rd, wl_or, npre, nwl, nsae);
    chk("wr_latency", 0, lat, 5);
    chk("wr_rsp_err", 0, 32'(err), 32'(0));
    chk("wr_wl_pattern", 0, 32'(wl_or), 32'h08);
    chk("wr_pre_len", 0, npre, 2);
    chk("wr_wl_len", 0, nwl, 2);
    chk("wr_sae_len", 0, nsae, 0);
    chk("wr_data_value", 0, 32'(wdata_o[0]), 32'hA5);

    sa_val[0] = 8'h5C;
    run_req(0, 1'b0, 3'd3, 8'h00, lat, err, rd, wl_or, npre, nwl, nsae);
    chk("rd_latency", 0, lat, 6);
    chk("rd_rdata", 0, 32'(rd), 32'h5C);
    chk("rd_wl_pattern", 0, 32'(wl_or), 32'h08);
    chk("rd_wl_len", 0, nwl, 3);
    chk("rd_sae_len", 0, nsae, 1);
    chk("rd_keeps_wr_data", 0, 32'(wdata_o[0]), 32'hA5);

    run_req(0, 1'b1, 3'd5, 8'h3C, lat, err, rd, wl_or, npre, nwl, nsae);
    chk("wr2_latency", 0, lat, 5);
    chk("wr_keeps_rdata", 0, 32'(rdata_o[0]), 32'h5C);

    back_to_back(gap1, gap2);
    chk("b2b_write_to_read_gap", 0, gap1, 6);
    chk("b2b_read_to_write_gap", 0, gap2, 7);
    repeat (10) @(negedge clk);
    chk("b2b_rdata", 0, 32'(rdata_o[0]), 32'h77);
    chk("b2b_wr_data", 0, 32'(wdata_o[0]), 32'h99);

    // Short precharge, long wordline, two-cycle sense on the 6-row instance.
    sa_val[1] = 8'hC3;
    run_req(1, 1'b0, 3'd2, 8'h00, lat, err, rd, wl_or, npre, nwl, nsae);
    chk("sweep_rd_latency", 1, lat, 7);
    chk("sweep_rd_pre_len", 1, npre, 1);
    chk("sweep_rd_wl_len", 1, nwl, 5);
    chk("sweep_rd_sae_len", 1, nsae, 2);
    chk("sweep_rd_rdata", 1, 32'(rd), 32'hC3);
    run_req(1, 1'b1, 3'd4, 8'h5A, lat, err, rd, wl_or, npre, nwl, nsae);
    chk("sweep_wr_latency", 1, lat, 5);
    chk("sweep_wr_pre_len", 1, npre, 1);
    chk("sweep_wr_wl_len", 1, nwl, 3);
    chk("sweep_wr_wl_pattern", 1, 32'(wl_or), 32'h10);

    run_req(1, 1'b0, 3'd7, 8'h00, lat, err, rd, wl_or, npre, nwl, nsae);
    chk("oor_latency", 1, lat, 1);
    chk("oor_rsp_err", 1, 32'(err), 32'(1));
    chk("oor_wl_quiet", 1, 32'(wl_or), 32'(0));
    chk("oor_pre_quiet", 1, npre, 0);
    chk("oor_sae_quiet", 1, nsae, 0);
    chk("oor_rdata_held", 1, 32'(rdata_o[1]), 32'hC3);

    // Reset while the wordline is up during a write.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 3'd1; req_wdata[0] = 8'hF0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = rdy_o[0];
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (wl_o[0] != 8'h00);
    end
    chk("midrst_wl_seen", 0, 32'(got), 32'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_wl_sel", 0, 32'(wl_o[0]), 32'(0));
    chk("midrst_wr_en", 0, 32'(wren_o[0]), 32'(0));
    chk("midrst_wr_data", 0, 32'(wdata_o[0]), 32'(0));
    chk("midrst_rsp_valid", 0, 32'(rv_o[0]), 32'(0));
    chk("midrst_ready", 0, 32'(rdy_o[0]), 32'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    sa_val[0] = 8'h3A;
    run_req(0, 1'b0, 3'd0, 8'h00, lat, err, rd, wl_or, npre, nwl, nsae);
    chk("post_rst_rd_latency", 0, lat, 6);
    chk("post_rst_rd_rdata", 0, 32'(rd), 32'h3A);
    chk("post_rst_rd_wl_pattern", 0, 32'(wl_or), 32'h01);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
